audio_mixer: RTL and testbench
==============================

AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have parameter BITDEPTH, default 14, the voice sample and mix width in bits; all widths below assume 14.
REQ-002 SHALL have parameter VOLBITS, default 4, the per-voice volume width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  system clock, 8 MHz.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sample_clock  input  1  divided sample-rate clock from sample_clock; treated as asynchronous data, not as a clock.
REQ-006 voice0..voice3  input  14 each  unsigned voice outputs.
REQ-007 volume0..volume3  input  4 each  unsigned per-voice gain; gain = volume/16, 0 = mute.
REQ-008 mix_out  output  14  unsigned mixed sample.
REQ-009 mix_valid  output  1  one-clk pulse when mix_out updates.
REQ-010 clip  output  1  one-clk pulse coincident with mix_valid when the mix saturated.
REQ-011 missed  output  1  sticky flag: a sample edge arrived while busy.
REQ-012 pdm_out  output  1  first-order sigma-delta bitstream of mix_out.

Function
REQ-013 SHALL pass sample_clock through flops s1->s2->s3, all clocked by clk; edge = s2 AND NOT s3.
REQ-014 SHALL implement the states IDLE, MAC and DONE.
REQ-015 IDLE + edge: SHALL snapshot all voices and volumes, clear the 20-bit accumulator, set index=0, and go to MAC.
REQ-016 MAC: SHALL add voice[index]*volume[index] (14x4 -> 18-bit product) to the accumulator in each of 4 consecutive cycles, indices 0..3, then go to DONE.
REQ-017 DONE: SHALL compute m = acc >> 4; set mix_out = min(m, 16383); set clip = (m > 16383); pulse mix_valid; return to IDLE.
REQ-018 Accumulator SHALL be 20 bits and SHALL never wrap (max 4*16383*15 = 982980).
REQ-019 Input changes after the snapshot SHALL NOT affect the mix in progress.
REQ-020 Latency: with P0 = the first clk posedge sampling sample_clock high, the snapshot SHALL be taken at P2, the MAC SHALL run at P3..P6, and mix_out/mix_valid SHALL be registered at P7.
REQ-021 An edge in MAC or DONE SHALL be ignored and SHALL set missed; missed SHALL clear only on reset.
REQ-022 mix_out SHALL hold its value between updates.
REQ-023 Sigma-delta: {carry, sd_acc[13:0]} = sd_acc + mix_out every clk; pdm_out SHALL be the registered carry.
REQ-024 Over 16384 consecutive clks, the count of pdm_out ones SHALL equal mix_out when mix_out is constant.
REQ-025 mix_out = 0 SHALL give pdm_out constantly 0.
REQ-026 mix_out = 16383 SHALL give pdm_out high in all but one of every 16384 clks.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE; s1/s2/s3 = 0; accumulator, index and sd_acc = 0; mix_out = 0; mix_valid, clip, missed and pdm_out = 0.
REQ-028 Reset asserted mid-MAC SHALL abort the mix; no mix_valid SHALL follow.
REQ-029 If sample_clock is high when rst_n deasserts, exactly one mix cycle SHALL run (edge from the reset values of s2/s3).

Verification
REQ-030 Volumes all 0, voices random, 3 sample edges -> mix_valid three times, mix_out = 0, clip = 0, pdm_out constantly 0.
REQ-031 voice0 = 8192, volume0 = 15, others volume 0 -> mix_out = 7680 at P7, clip = 0, exactly 7680 ones in the next 16384 clks.
REQ-032 All voices 16383, all volumes 15 -> m = 61436, mix_out = 16383, clip pulses with mix_valid.
REQ-033 Second sample_clock rising edge at P4 -> ignored, missed = 1, single mix_valid at P7, missed persists until rst_n.
REQ-034 voice1 changed 16383 -> 0 at P3 (after the snapshot), volume1 = 15, others muted -> mix_out = 15359.
REQ-035 rst_n pulsed low at P4 -> all outputs 0 immediately, no mix_valid at P7, next edge mixes normally.

Source files
------------

// File: rtl/audio_mixer.sv
// Four-voice audio mixer: on each sample_clock rising edge, snapshots voices and volumes,
// multiply-accumulates them over four cycles, saturates the result and sigma-delta modulates it.
module audio_mixer #(
    parameter int BITDEPTH = 14,
    parameter int VOLBITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clock,
    input  logic [BITDEPTH-1:0] voice0,
    input  logic [BITDEPTH-1:0] voice1,
    input  logic [BITDEPTH-1:0] voice2,
    input  logic [BITDEPTH-1:0] voice3,
    input  logic [VOLBITS-1:0]  volume0,
    input  logic [VOLBITS-1:0]  volume1,
    input  logic [VOLBITS-1:0]  volume2,
    input  logic [VOLBITS-1:0]  volume3,
    output logic [BITDEPTH-1:0] mix_out,
    output logic                mix_valid,
    output logic                clip,
    output logic                missed,
    output logic                pdm_out
);

    localparam int PRODW = BITDEPTH + VOLBITS;
    // Two guard bits hold the sum of four full-scale products without wrapping.
    localparam int ACCW  = PRODW + 2;
    localparam int MW    = ACCW - VOLBITS;
    localparam logic [MW-1:0] MAX_M = {2'b00, {BITDEPTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [ACCW-1:0]     acc_q, acc_d;
    logic [1:0]          idx_q, idx_d;
    logic [BITDEPTH-1:0] snap_voice_q [4];
    logic [BITDEPTH-1:0] snap_voice_d [4];
    logic [VOLBITS-1:0]  snap_vol_q [4];
    logic [VOLBITS-1:0]  snap_vol_d [4];
    logic [BITDEPTH-1:0] mix_out_q, mix_out_d;
    logic                mix_valid_q, mix_valid_d;
    logic                clip_q, clip_d;
    logic                missed_q, missed_d;
    logic [BITDEPTH-1:0] sd_acc_q, sd_acc_d;
    logic                pdm_q, pdm_d;

    logic                sample_edge;
    logic [PRODW-1:0]    prod;
    logic [MW-1:0]       m;

    assign sample_edge = s2_q & ~s3_q;
    assign prod        = PRODW'(snap_voice_q[idx_q]) * PRODW'(snap_vol_q[idx_q]);
    assign m           = acc_q[ACCW-1:VOLBITS];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        snap_voice_d = snap_voice_q;
        snap_vol_d   = snap_vol_q;
        mix_out_d    = mix_out_q;
        mix_valid_d  = 1'b0;
        clip_d       = 1'b0;
        missed_d     = missed_q;

        case (state_q)
            IDLE: begin
                if (sample_edge) begin
                    snap_voice_d[0] = voice0;
                    snap_voice_d[1] = voice1;
                    snap_voice_d[2] = voice2;
                    snap_voice_d[3] = voice3;
                    snap_vol_d[0]   = volume0;
                    snap_vol_d[1]   = volume1;
                    snap_vol_d[2]   = volume2;
                    snap_vol_d[3]   = volume3;
                    acc_d           = '0;
                    idx_d           = 2'd0;
                    state_d         = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m > MAX_M) begin
                    mix_out_d = MAX_M[BITDEPTH-1:0];
                    clip_d    = 1'b1;
                end else begin
                    mix_out_d = m[BITDEPTH-1:0];
                end
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A sample edge while a mix is in flight is dropped but remembered.
        if (sample_edge && (state_q != IDLE)) begin
            missed_d = 1'b1;
        end

        {pdm_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, mix_out_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_voice_q[i] <= '0;
                snap_vol_q[i]   <= '0;
            end
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            missed_q    <= 1'b0;
            sd_acc_q    <= '0;
            pdm_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= sample_clock;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            snap_voice_q <= snap_voice_d;
            snap_vol_q   <= snap_vol_d;
            mix_out_q    <= mix_out_d;
            mix_valid_q  <= mix_valid_d;
            clip_q       <= clip_d;
            missed_q     <= missed_d;
            sd_acc_q     <= sd_acc_d;
            pdm_q        <= pdm_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;
    assign missed    = missed_q;
    assign pdm_out   = pdm_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Randomized bench for audio_mixer: expected mixes come from a plain arithmetic model of the
// weighted sum, saturation and pulse-density rules, queued and matched against each mix_valid.
`timescale 1ns/1ps
module tb_audio_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_clock = 1'b0;
    logic [13:0] voice0 = '0, voice1 = '0, voice2 = '0, voice3 = '0;
    logic [3:0]  volume0 = '0, volume1 = '0, volume2 = '0, volume3 = '0;
    logic [13:0] mix_out;
    logic        mix_valid, clip, missed, pdm_out;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    bit pdm_zero_mode = 1'b0;
    int vo [4];
    int vl [4];
    logic [14:0] exp_q [$];

    audio_mixer #(.BITDEPTH(14), .VOLBITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_clock(sample_clock),
        .voice0(voice0), .voice1(voice1), .voice2(voice2), .voice3(voice3),
        .volume0(volume0), .volume1(volume1), .volume2(volume2), .volume3(volume3),
        .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip),
        .missed(missed), .pdm_out(pdm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mix_valid) valid_cnt++;
        if (clip) check("clip_with_valid", 32'(mix_valid), 32'd1);
        if (pdm_zero_mode) check("pdm_zero", 32'(pdm_out), 32'd0);
    end

    task automatic drive();
        voice0 = 14'(vo[0]); voice1 = 14'(vo[1]); voice2 = 14'(vo[2]); voice3 = 14'(vo[3]);
        volume0 = 4'(vl[0]); volume1 = 4'(vl[1]); volume2 = 4'(vl[2]); volume3 = 4'(vl[3]);
    endtask

    task automatic randomize_inputs();
        bit loud;
        loud = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            vo[i] = loud ? $urandom_range(10000, 16383) : $urandom_range(0, 16383);
            vl[i] = loud ? $urandom_range(10, 15) : $urandom_range(0, 15);
        end
        drive();
    endtask

    // Gain is volume/16 per voice; the sum saturates at full scale.
    function automatic logic [14:0] model();
        int sum;
        int m;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += vo[i] * vl[i];
        m = sum / 16;
        if (m > 16383) return {1'b1, 14'd16383};
        return {1'b0, 14'(m)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_sample(input bit change_mid);
        int          lat;
        bit          seen;
        logic [14:0] exp;
        exp_q.push_back(model());
        sample_clock = 1'b1;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick();
            if (mix_valid) begin
                seen = 1'b1;
                lat = i;
            end
            if (i == 2) sample_clock = 1'b0;
            if (i == 3 && change_mid) randomize_inputs();
        end
        check("latency", 32'(lat), 32'd8);
        exp = exp_q.pop_front();
        if (seen) begin
            check("mix_out", 32'(mix_out), 32'(exp[13:0]));
            check("clip", 32'(clip), 32'(exp[14]));
            tick();
            check("valid_single", 32'(mix_valid), 32'd0);
            check("mix_hold", 32'(mix_out), 32'(exp[13:0]));
        end
        tick();
        tick();
    endtask

    task automatic count_pdm(input int n, input int exp_ones);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ones += int'(pdm_out);
        end
        check("pdm_ones", 32'(ones), 32'(exp_ones));
    endtask

    initial begin
        int vc0;
        logic [14:0] exp;

        repeat (3) tick();
        check("rst_mix_out", 32'(mix_out), 32'd0);
        check("rst_mix_valid", 32'(mix_valid), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        check("rst_pdm", 32'(pdm_out), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single loud voice at half scale, full volume.
        vo = '{8192, 0, 0, 0};
        vl = '{15, 0, 0, 0};
        drive();
        run_sample(1'b0);
        count_pdm(16384, 7680);

        // Inputs change right after the snapshot.
        vo = '{0, 16383, 0, 0};
        vl = '{0, 15, 0, 0};
        drive();
        exp_q.push_back(model());
        sample_clock = 1'b1;
        vc0 = valid_cnt;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) sample_clock = 1'b0;
            if (i == 3) begin
                vo[1] = 0;
                drive();
            end
        end
        exp = exp_q.pop_front();
        check("snapshot_valid", 32'(mix_valid), 32'd1);
        check("snapshot_mix", 32'(mix_out), 32'(exp[13:0]));
        repeat (3) tick();

        // Full scale everywhere saturates.
        vo = '{16383, 16383, 16383, 16383};
        vl = '{15, 15, 15, 15};
        drive();
        run_sample(1'b0);
        count_pdm(16384, 16383);

        for (int k = 0; k < 24; k++) begin
            randomize_inputs();
            run_sample(1'($urandom_range(0, 1)));
        end

        // Second edge while mixing is dropped and flagged.
        randomize_inputs();
        exp = model();
        vc0 = valid_cnt;
        sample_clock = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 2) sample_clock = 1'b0;
            if (i == 4) sample_clock = 1'b1;
            if (i == 6) sample_clock = 1'b0;
            if (i == 8) check("missed_mix", 32'(mix_out), 32'(exp[13:0]));
        end
        check("missed_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
        check("missed_set", 32'(missed), 32'd1);
        repeat (20) tick();
        check("missed_sticky", 32'(missed), 32'd1);
        rst_n = 1'b0;
        #1;
        check("missed_cleared", 32'(missed), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset in the middle of a mix.
        randomize_inputs();
        run_sample(1'b0);
        randomize_inputs();
        sample_clock = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) sample_clock = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_mix_out", 32'(mix_out), 32'd0);
        check("abort_valid", 32'(mix_valid), 32'd0);
        check("abort_clip", 32'(clip), 32'd0);
        check("abort_missed", 32'(missed), 32'd0);
        check("abort_pdm", 32'(pdm_out), 32'd0);
        vc0 = valid_cnt;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);
        randomize_inputs();
        run_sample(1'b0);

        // sample_clock already high when reset releases.
        randomize_inputs();
        exp = model();
        sample_clock = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        vc0 = valid_cnt;
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mix_valid) check("rel_mix", 32'(mix_out), 32'(exp[13:0]));
        end
        check("rel_valid_cnt", 32'(valid_cnt - vc0), 32'd1);
        sample_clock = 1'b0;
        repeat (4) tick();

        // Muted voices keep the bitstream silent.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vo[i] = $urandom_range(0, 16383);
            vl[i] = 0;
        end
        drive();
        pdm_zero_mode = 1'b1;
        vc0 = valid_cnt;
        repeat (3) run_sample(1'b0);
        check("mute_valid_cnt", 32'(valid_cnt - vc0), 32'd3);
        repeat (50) tick();
        pdm_zero_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
